ad56x4_sched: RTL

- Setpoint scheduler in front of the three-chip AD56x4 slow-DAC serial driver (one shared trigger, three parallel shift paths, four channels per chip).
- Holds a 3x4 register file of signed 16-bit setpoints with dirty bits, written by the host.
- Sequences reconfigure/load/trigger pulses into the driver and waits on its busy flag.
- Round-robins across channels so every changed setpoint reaches the DACs with bounded latency; runs a reference-config frame after reset or on request.

---
 rtl/ad56x4_sched_pkg.sv | 21 ++
 rtl/ad56x4_rr_pick.sv | 28 ++
 rtl/ad56x4_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ad56x4_sched_pkg.sv
// Shared definitions for the AD56x4 setpoint scheduler: FSM encoding,
// array geometry and the driver-side command constants.
package ad56x4_sched_pkg;

  localparam int NCHIP = 3;
  localparam int NCHAN = 4;

  // Write-and-update command code and broadcast address used by the driver.
  localparam logic [4:0] DAC_CMD  = 5'b00011;
  localparam logic [2:0] ALL_DACS = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CFG_RC,
    LOAD,
    TRIG,
    WAIT0,
    WAIT_BUSY
  } state_t;

endpackage

// File: rtl/ad56x4_rr_pick.sv
// Round-robin first-set finder: returns the first channel at or after ptr
// (wrapping modulo 4) whose request bit is set.
module ad56x4_rr_pick
  import ad56x4_sched_pkg::*;
(
  input  logic [NCHAN-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       c,
  output logic             vld
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    c   = ptr;
    vld = 1'b0;
    idx = ptr;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        c   = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad56x4_sched.sv
// Setpoint scheduler for three AD56x4 DACs behind one shared serial driver.
// Holds a 3x4 setpoint file with dirty bits, runs a reference-config frame
// after reset or on request, and otherwise pushes changed channels to the
// driver round-robin, one channel (all three chips) per frame.
module ad56x4_sched
  import ad56x4_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CW          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_chip,
  input  logic [1:0]  wr_chan,
  input  logic [15:0] wr_data,
  input  logic        cfg_req,
  input  logic        err_clr,
  input  logic        sdac_busy,
  output logic        reconfig,
  output logic        sdac_trig,
  output logic        load1,
  output logic        load2,
  output logic        load3,
  output logic [2:0]  addr1,
  output logic [2:0]  addr2,
  output logic [2:0]  addr3,
  output logic [15:0] voltage1,
  output logic [15:0] voltage2,
  output logic [15:0] voltage3,
  output logic        pending,
  output logic        err,
  output logic [15:0] frame_cnt
);

  state_t state, state_d;

  logic signed [15:0] rf     [NCHIP][NCHAN];
  logic [NCHAN-1:0]   dirty  [NCHIP];
  logic signed [15:0] volt_q [NCHIP];
  logic [2:0]         addr_q;
  logic               load_q;
  logic [NCHAN-1:0]   chan_dirty;
  logic               cfg_pend;
  logic               is_cfg;
  logic [1:0]         ptr;
  logic [1:0]         sel_c;
  logic [1:0]         pick_c;
  logic               pick_vld;
  logic [CW-1:0]      wcnt;
  logic               timeout;
  logic               done;
  logic               wr_ok;
  logic               start_data;

  // Writes to the nonexistent fourth chip are dropped.
  assign wr_ok      = wr_en && (wr_chip < 2'(NCHIP));
  assign start_data = (state == IDLE) && (state_d == LOAD);

  // A channel needs a frame if any chip has a pending change on it.
  always_comb begin
    chan_dirty = '0;
    for (int n = 0; n < NCHIP; n++) chan_dirty = chan_dirty | dirty[n];
  end

  assign pending = cfg_pend | (|chan_dirty);

  ad56x4_rr_pick u_pick (
    .req (chan_dirty),
    .ptr (ptr),
    .c   (pick_c),
    .vld (pick_vld)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; new frames start only once the driver is idle.
  always_comb begin
    state_d = state;
    timeout = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (!sdac_busy) begin
          if (cfg_pend)      state_d = CFG_RC;
          else if (pick_vld) state_d = LOAD;
        end
      end
      CFG_RC: state_d = LOAD;
      LOAD:   state_d = TRIG;
      TRIG:   state_d = WAIT0;
      // Driver busy rises one cycle after the trigger, so skip one cycle.
      WAIT0:  state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!sdac_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wcnt == CW'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control: registered strobes, config request tracking, pointer, timeout, counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reconfig  <= 1'b0;
      load_q    <= 1'b0;
      sdac_trig <= 1'b0;
      cfg_pend  <= 1'b1;
      is_cfg    <= 1'b0;
      sel_c     <= '0;
      ptr       <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      reconfig  <= (state_d == CFG_RC);
      load_q    <= (state_d == LOAD);
      sdac_trig <= (state_d == TRIG);
      // A request arriving during CFG_RC survives the clear and runs again.
      if (cfg_req)                cfg_pend <= 1'b1;
      else if (state == CFG_RC)   cfg_pend <= 1'b0;
      if ((state == IDLE) && (state_d == CFG_RC)) begin
        is_cfg <= 1'b1;
      end else if (start_data) begin
        is_cfg <= 1'b0;
        sel_c  <= pick_c;
      end
      if ((state == LOAD) && !is_cfg) ptr <= sel_c + 2'd1;
      wcnt <= (state == WAIT_BUSY) ? wcnt + 1'b1 : '0;
      // A timeout in the same cycle as err_clr keeps err set.
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Setpoint file, dirty bits and the address/voltage presented with load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCHIP; n++) begin
        for (int k = 0; k < NCHAN; k++) rf[n][k] <= '0;
        dirty[n]  <= '0;
        volt_q[n] <= '0;
      end
      addr_q <= '0;
    end else begin
      if ((state == LOAD) && !is_cfg) begin
        for (int n = 0; n < NCHIP; n++) dirty[n][sel_c] <= 1'b0;
      end
      // Host write comes after the clear so a colliding write keeps dirty set.
      if (wr_ok) begin
        rf[wr_chip][wr_chan]    <= $signed(wr_data);
        dirty[wr_chip][wr_chan] <= 1'b1;
      end
      if (start_data) begin
        addr_q <= {1'b0, pick_c};
        // Forward a same-cycle write so the captured value is never stale.
        for (int n = 0; n < NCHIP; n++) begin
          if (wr_ok && (wr_chip == 2'(n)) && (wr_chan == pick_c))
            volt_q[n] <= $signed(wr_data);
          else
            volt_q[n] <= rf[n][pick_c];
        end
      end else if (state == CFG_RC) begin
        addr_q <= '0;
        for (int n = 0; n < NCHIP; n++) volt_q[n] <= '0;
      end
    end
  end

  assign load1    = load_q;
  assign load2    = load_q;
  assign load3    = load_q;
  assign addr1    = addr_q;
  assign addr2    = addr_q;
  assign addr3    = addr_q;
  assign voltage1 = volt_q[0];
  assign voltage2 = volt_q[1];
  assign voltage3 = volt_q[2];

endmodule
